axis_adder_sink: RTL and testbench
==================================

Name: axis_adder_sink

Overview:
- AXI-Stream sink stage directly downstream of the client block.
- Accepts the client's operand stream and sums the low DATA_WIDTH bits of every accepted beat.
- On the beat flagged tlast, presents the final sum and the beat count on a valid/ready result port.
- Then clears and accepts the next transaction.

Parameters:
- AXIS_DATAW, 512, width of the incoming tdata bus.
- AXIS_DESTW, 5, width of tdest.
- AXIS_USERW, 5, width of tuser.
- DATA_WIDTH, 64, operand width; operand is tdata[DATA_WIDTH-1:0], zero-extended.
- ACC_WIDTH, 72, accumulator and result width.
- EXPECTED_SRC, 3, tuser value accepted when the source filter is compiled in.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- axis_adder_interface_tvalid  in  1  beat valid from the upstream client.
- axis_adder_interface_tlast  in  1  last beat of a transaction.
- axis_adder_interface_tdest  in  AXIS_DESTW  destination; ignored.
- axis_adder_interface_tuser  in  AXIS_USERW  source address.
- axis_adder_interface_tdata  in  AXIS_DATAW  payload.
- axis_adder_interface_tready  out  1  sink can accept a beat.
- result_valid  out  1  result held.
- result_ready  in  1  result consumer ready.
- result_sum  out  ACC_WIDTH  transaction sum.
- result_count  out  16  accepted beats in the transaction, including the last.
- result_overflow  out  1  accumulator carried out during the transaction.

Behaviour:
- Reset:
  - state=ACCUM; acc, count and overflow cleared.
  - result_valid=0, result_sum=0, result_count=0, result_overflow=0.
  - tready=0 while rst is high.
  - Reset mid-transaction or mid-result discards all partial state; no result is emitted.
- Handshake:
  - A beat is accepted when tvalid && tready.
  - tready = ~rst && (state==ACCUM); combinational from the state register.
  - tvalid without tready: data is held by upstream, no effect here.
- State ACCUM, on each accepted beat:
  - acc <= acc + zext(tdata[DATA_WIDTH-1:0]), modulo 2^ACC_WIDTH.
  - A carry out of bit ACC_WIDTH-1 sets the sticky overflow flag.
  - count <= count+1, saturating at 16'hFFFF.
- Accepted beat with tlast:
  - Register result_sum = acc+operand, result_count = count+1 (saturating), result_overflow = sticky | this beat's carry.
  - Clear acc, count and overflow; go to state RESULT.
  - result_valid is high the cycle after the accepting edge. Latency is 1 cycle from last-beat acceptance.
- Single-beat transaction (tlast on the first beat): result_count=1, result_sum=operand.
- State RESULT:
  - tready=0; result outputs held stable while result_valid && !result_ready.
  - On result_valid && result_ready: result_valid <= 0, state <= ACCUM; tready is high the following cycle.
  - result_sum, result_count and result_overflow retain their last values after the handshake.
- No beat is accepted in the cycle the result is taken (tready is still 0 then). Minimum gap between transactions is 1 cycle.
- tdest is unused. tdata bits above DATA_WIDTH are ignored.

Optional Feature:
- Macro: ADDER_SRC_FILTER_EN.
- Defined:
  - Beats with tuser != EXPECTED_SRC are still accepted (tready unchanged) but do not modify acc, count or overflow.
  - A mismatched beat carrying tlast is dropped entirely and does not end the transaction.
  - Adds output port dropped_count (16 bits, saturating, cleared only by rst) counting discarded beats.
- Not defined: tuser is ignored, every accepted beat is summed, and dropped_count does not exist.

Test Plan:
- Reset, then stream 1,2,3,4 with tlast on 4, result_ready=1 → result_valid 1 cycle after the 4th acceptance; result_sum=10, result_count=4, result_overflow=0; tready high again 2 cycles after the last beat.
- Single beat 0x55 with tlast → result_sum=0x55, result_count=1.
- Backpressure: result_ready=0 for 5 cycles after a result, tvalid held high with the next data → tready stays 0, result outputs stable; after result_ready=1, the next transaction sums correctly starting from 0.
- Overflow: ACC_WIDTH=72, stream 2^64-1 257 times with tlast on the last → result_sum = 257·(2^64-1) mod 2^72, result_overflow=1; the following transaction 5,5 → result_sum=10, result_overflow=0.
- Reset asserted after 2 of 4 beats, then stream 7,8 with tlast on 8 → result_sum=15, result_count=2, no earlier result emitted.
- With ADDER_SRC_FILTER_EN and EXPECTED_SRC=3: beats (tuser=3,10), (tuser=1,100), (tuser=3,20,tlast) → result_sum=30, result_count=2, dropped_count=1.

Source files
------------

// File: rtl/axis_adder_sink.sv
// rtl/axis_adder_sink.sv - AXI-Stream sink that sums operand beats and reports a per-transaction result
//
// Purpose:
//   Accepts the client's operand stream, accumulates the low DATA_WIDTH bits
//   of every accepted beat, and on the tlast beat presents sum, beat count and
//   overflow on a valid/ready result port. The sink stalls (tready low) until
//   the result is taken, then starts the next transaction from zero.
//
// Optional feature (macro ADDER_SRC_FILTER_EN):
//   Beats whose tuser differs from EXPECTED_SRC are accepted but discarded;
//   they are counted on the extra output dropped_count.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   axis_adder_interface_tvalid/tready beat handshake
//   axis_adder_interface_tlast        last beat of a transaction
//   axis_adder_interface_tdest        unused
//   axis_adder_interface_tuser        source address (filter only)
//   axis_adder_interface_tdata        payload, low DATA_WIDTH bits used
//   result_valid/result_ready         result handshake
//   result_sum, result_count          transaction sum and accepted beat count
//   result_overflow                   accumulator carried out during transaction
//   dropped_count                     discarded beats (ADDER_SRC_FILTER_EN only)

module axis_adder_sink #(
    parameter int AXIS_DATAW   = 512,
    parameter int AXIS_DESTW   = 5,
    parameter int AXIS_USERW   = 5,
    parameter int DATA_WIDTH   = 64,
    parameter int ACC_WIDTH    = 72,
    parameter int EXPECTED_SRC = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  axis_adder_interface_tvalid,
    input  logic                  axis_adder_interface_tlast,
    input  logic [AXIS_DESTW-1:0] axis_adder_interface_tdest,
    input  logic [AXIS_USERW-1:0] axis_adder_interface_tuser,
    input  logic [AXIS_DATAW-1:0] axis_adder_interface_tdata,
    output logic                  axis_adder_interface_tready,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [ACC_WIDTH-1:0]  result_sum,
    output logic [15:0]           result_count,
    output logic                  result_overflow
`ifdef ADDER_SRC_FILTER_EN
    ,
    output logic [15:0]           dropped_count
`endif
);

    typedef enum logic {
        S_ACCUM  = 1'b0,
        S_RESULT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [ACC_WIDTH-1:0]  r_acc;
    logic [15:0]           r_count;
    logic                  r_overflow;
    logic [ACC_WIDTH-1:0]  r_result_sum;
    logic [15:0]           r_result_count;
    logic                  r_result_overflow;

    logic                  w_tready;
    logic                  w_beat;
    logic                  w_keep;
    logic                  w_take;
    logic [ACC_WIDTH-1:0]  w_operand;
    logic [ACC_WIDTH:0]    w_sum_ext;
    logic [15:0]           w_count_inc;

    // Inputs that carry no information for this stage.
    logic                  w_unused_bits;
    assign w_unused_bits = ^{axis_adder_interface_tdest,
                             axis_adder_interface_tdata[AXIS_DATAW-1:DATA_WIDTH],
                             axis_adder_interface_tuser};

    assign w_beat    = axis_adder_interface_tvalid && w_tready;
    assign w_operand = ACC_WIDTH'(axis_adder_interface_tdata[DATA_WIDTH-1:0]);
    assign w_sum_ext = {1'b0, r_acc} + {1'b0, w_operand};
    assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;

`ifdef ADDER_SRC_FILTER_EN
    logic [15:0] r_dropped;
    assign w_keep        = (axis_adder_interface_tuser == AXIS_USERW'(EXPECTED_SRC));
    assign dropped_count = r_dropped;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dropped <= 16'd0;
        end else if (w_beat && !w_keep && (r_dropped != 16'hFFFF)) begin
            r_dropped <= r_dropped + 16'd1;
        end
    end
`else
    assign w_keep = 1'b1;
`endif

    // A beat contributes to the transaction only when it passes the filter.
    assign w_take = w_beat && w_keep;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_ACCUM:  if (w_take && axis_adder_interface_tlast) w_next_state = S_RESULT;
            S_RESULT: if (result_ready)                         w_next_state = S_ACCUM;
            default:  w_next_state = S_ACCUM;
        endcase
    end

    // Output logic
    always_comb begin
        w_tready     = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            S_ACCUM:  w_tready     = ~rst;
            S_RESULT: result_valid = 1'b1;
            default: begin
                w_tready     = 1'b0;
                result_valid = 1'b0;
            end
        endcase
    end

    // Accumulator and result registers; the last beat folds straight into the
    // result so the accumulator is already clear for the next transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc             <= '0;
            r_count           <= 16'd0;
            r_overflow        <= 1'b0;
            r_result_sum      <= '0;
            r_result_count    <= 16'd0;
            r_result_overflow <= 1'b0;
        end else if (w_take) begin
            if (axis_adder_interface_tlast) begin
                r_result_sum      <= w_sum_ext[ACC_WIDTH-1:0];
                r_result_count    <= w_count_inc;
                r_result_overflow <= r_overflow | w_sum_ext[ACC_WIDTH];
                r_acc             <= '0;
                r_count           <= 16'd0;
                r_overflow        <= 1'b0;
            end else begin
                r_acc      <= w_sum_ext[ACC_WIDTH-1:0];
                r_count    <= w_count_inc;
                r_overflow <= r_overflow | w_sum_ext[ACC_WIDTH];
            end
        end
    end

    assign axis_adder_interface_tready = w_tready;
    assign result_sum                  = r_result_sum;
    assign result_count                = r_result_count;
    assign result_overflow             = r_result_overflow;

endmodule

// File: tb/tb_axis_adder_sink.sv
// tb/tb_axis_adder_sink.sv - directed self-checking bench for axis_adder_sink

module tb_axis_adder_sink;

    localparam int AXIS_DATAW = 512;
    localparam int AXIS_DESTW = 5;
    localparam int AXIS_USERW = 5;
    localparam int DATA_WIDTH = 64;
    localparam int ACC_WIDTH  = 72;

    logic                  clk;
    logic                  rst;
    logic                  tvalid;
    logic                  tlast;
    logic [AXIS_DESTW-1:0] tdest;
    logic [AXIS_USERW-1:0] tuser;
    logic [AXIS_DATAW-1:0] tdata;
    logic                  tready;
    logic                  result_valid;
    logic                  result_ready;
    logic [ACC_WIDTH-1:0]  result_sum;
    logic [15:0]           result_count;
    logic                  result_overflow;
`ifdef ADDER_SRC_FILTER_EN
    logic [15:0]           dropped_count;
`endif

    int checks;
    int errors;

    axis_adder_sink #(
        .AXIS_DATAW(AXIS_DATAW), .AXIS_DESTW(AXIS_DESTW), .AXIS_USERW(AXIS_USERW),
        .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .EXPECTED_SRC(3)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .axis_adder_interface_tvalid (tvalid),
        .axis_adder_interface_tlast  (tlast),
        .axis_adder_interface_tdest  (tdest),
        .axis_adder_interface_tuser  (tuser),
        .axis_adder_interface_tdata  (tdata),
        .axis_adder_interface_tready (tready),
        .result_valid                (result_valid),
        .result_ready                (result_ready),
        .result_sum                  (result_sum),
        .result_count                (result_count),
        .result_overflow             (result_overflow)
`ifdef ADDER_SRC_FILTER_EN
        ,
        .dropped_count               (dropped_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one beat and returns 1 time unit after the edge that accepted it.
    task automatic send_beat(input logic [63:0] d, input logic last, input logic [4:0] user);
        int guard;
        tvalid = 1'b1;
        tdata  = AXIS_DATAW'(d);
        tlast  = last;
        tuser  = user;
        guard  = 0;
        while (!tready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            checks++; errors++;
            $display("FAIL send_beat timeout: tready=%0b required 1", tready);
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tvalid = 1'b0;
        tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tdest = '0; tuser = 5'd3; tdata = '0; result_ready = 1'b1;
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %0b required 0", tready); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b required 0", result_valid); end
        checks++; if (result_sum !== 72'd0) begin errors++; $display("FAIL reset_sum: got %0h required 0", result_sum); end
        checks++; if (result_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", result_count); end
        checks++; if (result_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b required 0", result_overflow); end
        rst = 1'b0;
        #1;
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready: got %0b required 1", tready); end
    endtask

    task automatic test_basic_sum();
        result_ready = 1'b1;
        send_beat(64'd1, 1'b0, 5'd3);
        send_beat(64'd2, 1'b0, 5'd3);
        send_beat(64'd3, 1'b0, 5'd3);
        send_beat(64'd4, 1'b1, 5'd3);
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: valid=%0b required 1", result_valid); end
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL basic_tready_low: got %0b required 0", tready); end
        checks++; if (result_sum !== 72'd10) begin errors++; $display("FAIL basic_sum: got %0d required 10", result_sum); end
        checks++; if (result_count !== 16'd4) begin errors++; $display("FAIL basic_count: got %0d required 4", result_count); end
        checks++; if (result_overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %0b required 0", result_overflow); end
        @(posedge clk); #1;
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL basic_tready_back: got %0b required 1", tready); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %0b required 0", result_valid); end
        checks++; if (result_sum !== 72'd10) begin errors++; $display("FAIL basic_sum_retained: got %0d required 10", result_sum); end
    endtask

    task automatic test_single_beat();
        result_ready = 1'b1;
        send_beat(64'h55, 1'b1, 5'd3);
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b required 1", result_valid); end
        checks++; if (result_sum !== 72'h55) begin errors++; $display("FAIL single_sum: got %0h required 55", result_sum); end
        checks++; if (result_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d required 1", result_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        result_ready = 1'b0;
        send_beat(64'd6, 1'b0, 5'd3);
        send_beat(64'd9, 1'b1, 5'd3);
        tvalid = 1'b1; tdata = AXIS_DATAW'(64'd100); tlast = 1'b0; tuser = 5'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (tready !== 1'b0) begin errors++; $display("FAIL bp_tready cycle %0d: got %0b required 0", i, tready); end
            checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d: got %0b required 1", i, result_valid); end
            checks++; if (result_sum !== 72'd15 || result_count !== 16'd2) begin
                errors++; $display("FAIL bp_stable cycle %0d: sum=%0d count=%0d required 15 2", i, result_sum, result_count);
            end
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (result_valid !== 1'b0 || tready !== 1'b1) begin
            errors++; $display("FAIL bp_release: valid=%0b tready=%0b required 0 1", result_valid, tready);
        end
        send_beat(64'd100, 1'b0, 5'd3);
        send_beat(64'd23, 1'b1, 5'd3);
        checks++; if (result_sum !== 72'd123) begin errors++; $display("FAIL bp_next_sum: got %0d required 123", result_sum); end
        checks++; if (result_count !== 16'd2) begin errors++; $display("FAIL bp_next_count: got %0d required 2", result_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        logic [ACC_WIDTH-1:0] exp_sum;
        exp_sum = 72'h00_FFFF_FFFF_FFFF_FEFF;
        result_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            send_beat(64'hFFFF_FFFF_FFFF_FFFF, (i == 256), 5'd3);
        end
        checks++; if (result_sum !== exp_sum) begin errors++; $display("FAIL ovf_sum: got %0h required %0h", result_sum, exp_sum); end
        checks++; if (result_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b required 1", result_overflow); end
        checks++; if (result_count !== 16'd257) begin errors++; $display("FAIL ovf_count: got %0d required 257", result_count); end
        @(posedge clk); #1;
        send_beat(64'd5, 1'b0, 5'd3);
        send_beat(64'd5, 1'b1, 5'd3);
        checks++; if (result_sum !== 72'd10) begin errors++; $display("FAIL ovf_next_sum: got %0d required 10", result_sum); end
        checks++; if (result_overflow !== 1'b0) begin errors++; $display("FAIL ovf_next_flag: got %0b required 0", result_overflow); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        result_ready = 1'b1;
        send_beat(64'd1, 1'b0, 5'd3);
        send_beat(64'd2, 1'b0, 5'd3);
        apply_reset();
        #1;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %0b required 0", result_valid); end
        send_beat(64'd7, 1'b0, 5'd3);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_early_result: got %0b required 0", result_valid); end
        send_beat(64'd8, 1'b1, 5'd3);
        checks++; if (result_sum !== 72'd15) begin errors++; $display("FAIL mid_reset_sum: got %0d required 15", result_sum); end
        checks++; if (result_count !== 16'd2) begin errors++; $display("FAIL mid_reset_count: got %0d required 2", result_count); end
        @(posedge clk); #1;
        // Reset while a result is pending discards it.
        result_ready = 1'b0;
        send_beat(64'd9, 1'b1, 5'd3);
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL pend_valid: got %0b required 1", result_valid); end
        apply_reset();
        result_ready = 1'b1;
        #1;
        checks++; if (result_valid !== 1'b0 || result_sum !== 72'd0) begin
            errors++; $display("FAIL pend_reset: valid=%0b sum=%0d required 0 0", result_valid, result_sum);
        end
    endtask

`ifdef ADDER_SRC_FILTER_EN
    task automatic test_src_filter();
        apply_reset();
        result_ready = 1'b1;
        send_beat(64'd10, 1'b0, 5'd3);
        send_beat(64'd100, 1'b1, 5'd1);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL filt_drop_last: valid=%0b required 0", result_valid); end
        send_beat(64'd20, 1'b1, 5'd3);
        checks++; if (result_sum !== 72'd30) begin errors++; $display("FAIL filt_sum: got %0d required 30", result_sum); end
        checks++; if (result_count !== 16'd2) begin errors++; $display("FAIL filt_count: got %0d required 2", result_count); end
        checks++; if (dropped_count !== 16'd1) begin errors++; $display("FAIL filt_dropped: got %0d required 1", dropped_count); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_sum();
        test_single_beat();
        test_backpressure();
        test_overflow();
        test_reset_midstream();
`ifdef ADDER_SRC_FILTER_EN
        test_src_filter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
